// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory-stage load/store controller.
// Turns one load or store from the pipeline into a single request on a
// 32-bit memory bus. It stalls the pipeline until the memory acknowledges
// the request or a wait limit runs out, then returns the extended load data.
//
// Ports
//   clk, rst                     clock; synchronous active-low reset
//   memreadM, memwriteM          load / store request (both high = load)
//   memopM[2:0]                  access size and signedness
//   aluoutM, writedataM          byte address and store data
//   readdataM                    extended load result (valid in DONE)
//   stallM                       pipeline stall
//   adelM, adesM                 misaligned load / store
//   buserrM                      memory did not acknowledge in time
//   mem_req, mem_we, mem_be      memory request, write enable, byte lanes
//   mem_addr, mem_wdata          word address and replicated write data
//   mem_ack, mem_rdata           memory acknowledge and read data
module data_mem_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  memopM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM,
  output logic        buserrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Value of the wait counter in the last BUSY cycle before a timeout.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] data_q;
  logic        buserr_q;
  logic        load_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;

  logic        is_load, is_store, aligned, start;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign is_load  = memreadM;
  assign is_store = memwriteM & ~memreadM;
  assign start    = (state == IDLE) && (is_load || is_store) && aligned;

  // Alignment check and lane steering for the request being presented.
  // NOTE: every signal written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    aligned   = 1'b1;
    be_nxt    = 4'b1111;
    wdata_nxt = writedataM;
    if (memopM[2]) begin
      aligned = (aluoutM[1:0] == 2'b00);
    end else if (memopM[1]) begin
      aligned   = ~aluoutM[0];
      be_nxt    = aluoutM[1] ? 4'b1100 : 4'b0011;
      wdata_nxt = {2{writedataM[15:0]}};
    end else begin
      be_nxt    = 4'b0001 << aluoutM[1:0];
      wdata_nxt = {4{writedataM[7:0]}};
    end
    // A load always reads the whole word; lanes are picked on return.
    if (is_load) be_nxt = 4'b1111;
  end

  // Next-state and combinational outputs.
  always_comb begin
    state_nxt = state;
    stallM    = 1'b0;
    mem_req   = 1'b0;
    adelM     = 1'b0;
    adesM     = 1'b0;
    case (state)
      IDLE: begin
        if (is_load || is_store) begin
          if (aligned) begin
            stallM    = 1'b1;
            state_nxt = BUSY;
          end else begin
            adelM = is_load;
            adesM = is_store;
          end
        end
      end
      BUSY: begin
        stallM  = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || wait_cnt == LAST_WAIT) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      data_q    <= 32'd0;
      buserr_q  <= 1'b0;
      load_q    <= 1'b0;
      op_q      <= 3'd0;
      off_q     <= 2'd0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            wait_cnt  <= 8'd0;
            buserr_q  <= 1'b0;
            load_q    <= is_load;
            op_q      <= memopM;
            off_q     <= aluoutM[1:0];
            mem_we    <= is_store;
            mem_be    <= be_nxt;
            mem_addr  <= {aluoutM[31:2], 2'b00};
            mem_wdata <= wdata_nxt;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            data_q <= mem_rdata;
          end else if (wait_cnt == LAST_WAIT) begin
            data_q   <= 32'd0;
            buserr_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Load extension from the captured word.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = data_q[7:0];
      2'd1:    byte_sel = data_q[15:8];
      2'd2:    byte_sel = data_q[23:16];
      default: byte_sel = data_q[31:24];
    endcase
    half_sel = off_q[1] ? data_q[31:16] : data_q[15:0];
    if (op_q[2])
      load_ext = data_q;
    else if (op_q[1])
      load_ext = {{16{~op_q[0] & half_sel[15]}}, half_sel};
    else
      load_ext = {{24{~op_q[0] & byte_sel[7]}}, byte_sel};
  end

  assign readdataM = (state == DONE && load_q) ? load_ext : 32'd0;
  assign buserrM   = (state == DONE) && buserr_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, giving the maximum BUSY cycles waited for mem_ack before a bus error is declared (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset; rst=0 at a rising clk edge resets all state.
REQ-004 SHALL have ports memreadM, memwriteM  input  1 each  memory-stage load or store request; both high is treated as a load.
REQ-005 SHALL have port memopM  input  3  access size: 000 byte signed, 001 byte unsigned, 010 half signed, 011 half unsigned, 1xx word.
REQ-006 SHALL have ports aluoutM and writedataM  input  32 each  byte address and store data from the memory stage.
REQ-007 SHALL have port readdataM  output  32  extended load result for the writeback register.
REQ-008 SHALL have ports stallM, adelM, adesM, buserrM  output  1 each  pipeline stall, load-misaligned, store-misaligned, bus timeout.
REQ-009 SHALL have ports mem_req, mem_we  output  1 each, mem_be  output  4, mem_addr and mem_wdata  output  32 each  memory request side.
REQ-010 SHALL have ports mem_ack  input  1 and mem_rdata  input  32  memory response side.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-012 IDLE: a valid access (load or store, aligned) SHALL assert stallM combinationally and move to BUSY on the next edge; with no access, or a misaligned one, the FSM SHALL stay in IDLE with stallM=0.
REQ-013 Alignment: half accesses SHALL need aluoutM[0]=0 and word accesses SHALL need aluoutM[1:0]=00; byte accesses SHALL always be aligned.
REQ-014 Misaligned access in IDLE: adelM (load) or adesM (store) SHALL be 1 combinationally, with no memory request and no stall.
REQ-015 BUSY: mem_req=1 and stallM=1 SHALL hold, and mem_addr, mem_we, mem_be and mem_wdata SHALL be registered at the IDLE->BUSY edge and held stable.
REQ-016 mem_addr SHALL be {aluoutM[31:2],2'b00}.
REQ-017 Stores SHALL use little-endian byte enables: byte -> mem_be=0001<<aluoutM[1:0]; half -> 0011 (aluoutM[1]=0) or 1100; word -> 1111.
REQ-018 Store data SHALL be replicated across lanes: byte -> {4{wd[7:0]}}; half -> {2{wd[15:0]}}; word -> wd.
REQ-019 Loads SHALL drive mem_we=0 and mem_be=1111.
REQ-020 BUSY with mem_ack=1 SHALL capture mem_rdata in a data register and move to DONE.
REQ-021 BUSY SHALL count cycles with an 8-bit counter; if MAX_WAIT cycles elapse without ack, the FSM SHALL move to DONE with buserrM set and the data register loaded to 0.
REQ-022 DONE: stallM=0 and mem_req=0 SHALL hold, readdataM SHALL be valid, buserrM SHALL reflect the timeout, and the FSM SHALL return to IDLE on the next edge; the pipeline advances at this edge.
REQ-023 Load extension: select the byte at lane aluoutM[1:0], or the half at aluoutM[1]; signed ops SHALL sign-extend and unsigned ops SHALL zero-extend; word passes through unchanged.
REQ-024 readdataM SHALL be 0 outside DONE, and for stores.
REQ-025 mem_ack received in IDLE or DONE SHALL be ignored.
REQ-026 Minimum access time SHALL be 3 cycles (IDLE-stall, BUSY+ack, DONE) with 2 stall cycles; each extra wait cycle SHALL add one stall.
REQ-027 Back-to-back accesses SHALL be serviced: a new access presented in IDLE right after DONE starts a fresh transaction, and the wait counter SHALL be cleared on entry to BUSY.

Reset
REQ-028 rst=0 SHALL force IDLE, counter 0 and data register 0 on the next edge, from any state, including mid-BUSY.
REQ-029 After reset: mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0, readdataM=0, buserrM=0, and stallM follows REQ-012 combinationally.

Verification
REQ-030 Word load at 0x100 with ack in the first BUSY cycle and mem_rdata=0xDEADBEEF -> stallM high for 2 cycles, mem_addr=0x100, readdataM=0xDEADBEEF in DONE.
REQ-031 Signed byte load at 0x103 with mem_rdata=0x80FF0011 -> readdataM=0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-032 Half store at 0x06 with writedataM=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD.
REQ-033 Word load at 0x102 -> adelM=1, stallM=0, and mem_req never asserted.
REQ-034 MAX_WAIT=4 with ack never arriving -> 4 BUSY cycles, then DONE with buserrM=1, readdataM=0, and stallM released.
REQ-035 rst=0 in the second BUSY cycle -> next cycle in IDLE with mem_req=0, and a later late ack is ignored.
